// File: rtl/ws_pkg.sv
// Shared types and helpers for the weight-stationary convolution engine.
package ws_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int MAX_VEC_W = 1024;

  function automatic int acc_width(input int data_w, input int taps, input int cin_max);
    return 2 * data_w + $clog2(taps) + $clog2(cin_max);
  endfunction

  // Element idx of a packed vector, sign-extended from dw bits to 32 bits.
  function automatic logic signed [31:0] unpack_elem(input logic [MAX_VEC_W-1:0] vec,
                                                     input int idx, input int dw);
    logic [31:0] r;
    r = 32'(vec >> (idx * dw));
    for (int b = 0; b < 32; b++) begin
      r[b] = (b >= dw) ? r[dw-1] : r[b];
    end
    return signed'(r);
  endfunction

endpackage

// File: rtl/ws_mac_tree.sv
// TAPS signed multipliers (product regs) followed by a registered sum of all
// products; both stages advance only while en is high.
module ws_mac_tree
  import ws_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAPS   = 25,
  parameter int SUM_W  = 2 * DATA_W + $clog2(TAPS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [TAPS*DATA_W-1:0]  fmap_i,
  input  logic [TAPS*DATA_W-1:0]  weight_i,
  output logic signed [SUM_W-1:0] sum_o
);
  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0]    prod_d [TAPS];
  logic signed [PW-1:0]    prod_q [TAPS];
  logic signed [SUM_W-1:0] sum_d;
  logic signed [SUM_W-1:0] sum_q;

  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      prod_d[i] = PW'(unpack_elem(MAX_VEC_W'(fmap_i), i, DATA_W) *
                      unpack_elem(MAX_VEC_W'(weight_i), i, DATA_W));
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < TAPS; i++) begin
      sum_d = sum_d + SUM_W'(prod_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        prod_q[i] <= '0;
      end
      sum_q <= '0;
    end else if (en) begin
      for (int i = 0; i < TAPS; i++) begin
        prod_q[i] <= prod_d[i];
      end
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/ws_conv_engine.sv
// Weight-stationary convolution engine: latches one filter bank, streams fmaps
// windows and emits one signed sum per group of cin windows with valid/ready.
module ws_conv_engine
  import ws_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int TAPS     = 25,
  parameter int NUM_FILT = 2,
  parameter int ADDR_W   = 6,
  parameter int CIN_MAX  = 4,
  parameter int ACC_W    = acc_width(DATA_W, TAPS, CIN_MAX)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [$clog2(NUM_FILT)-1:0] filt_sel,
  input  logic [ADDR_W:0]             num_win,
  input  logic [$clog2(CIN_MAX):0]    cin,
  output logic [$clog2(NUM_FILT)-1:0] weight_sel,
  input  logic [TAPS*DATA_W-1:0]      weight_in,
  output logic                        cs,
  output logic                        we,
  output logic [ADDR_W-1:0]           fmaps_addr,
  input  logic [TAPS*DATA_W-1:0]      fmaps_in,
  output logic                        valid,
  input  logic                        ready,
  output logic signed [ACC_W-1:0]     acc,
  output logic                        busy,
  output logic                        done
);
  localparam int CW    = $clog2(CIN_MAX) + 1;
  localparam int SUM_W = 2 * DATA_W + $clog2(TAPS);
  localparam logic [ADDR_W:0] NW_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CIN_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_e                        state_q, state_d;
  logic                          busy_q, done_q;
  logic [$clog2(NUM_FILT)-1:0]   weight_sel_q;
  logic [ADDR_W:0]               num_win_q;
  logic [CW-1:0]                 cin_q, grp_cnt_q;
  logic [ADDR_W-1:0]             addr_q;
  logic [TAPS*DATA_W-1:0]        w_q;
  logic                          s1_vld_q, s1_last_q, s2_vld_q, s2_last_q, s3_vld_q, s3_last_q;
  logic signed [ACC_W-1:0]       grp_q, acc_q;
  logic                          valid_q;
  logic signed [SUM_W-1:0]       tree_sum_s;
  logic signed [ACC_W-1:0]       acc_sum_s;
  logic                          en_s, issue_s, last_addr_s, last_grp_s, pipe_empty_s;

  assign en_s         = !(valid_q && !ready);
  assign issue_s      = (state_q == RUN) && en_s;
  assign last_addr_s  = ({1'b0, addr_q} == (num_win_q - NW_ONE));
  assign last_grp_s   = (grp_cnt_q == (cin_q - CIN_ONE)) || last_addr_s;
  assign pipe_empty_s = !s1_vld_q && !s2_vld_q && !s3_vld_q;
  assign acc_sum_s    = grp_q + ACC_W'(tree_sum_s);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD_W : IDLE;
      LOAD_W:  state_d = RUN;
      RUN:     state_d = (issue_s && last_addr_s) ? DRAIN : RUN;
      DRAIN:   state_d = (pipe_empty_s && valid_q && ready) ? DONE : DRAIN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job parameters and filter are frozen at start; the address and group
  // counters only move on cycles that actually issue a window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      weight_sel_q <= '0;
      num_win_q    <= '0;
      cin_q        <= '0;
      addr_q       <= '0;
      grp_cnt_q    <= '0;
      w_q          <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (state_q == IDLE && start) begin
        weight_sel_q <= filt_sel;
        num_win_q    <= num_win;
        cin_q        <= cin;
        addr_q       <= '0;
        grp_cnt_q    <= '0;
      end
      if (state_q == LOAD_W) begin
        w_q <= weight_in;
      end
      if (issue_s) begin
        if (!last_addr_s) begin
          addr_q <= addr_q + 1'b1;
        end
        grp_cnt_q <= last_grp_s ? '0 : grp_cnt_q + 1'b1;
      end
    end
  end

  ws_mac_tree #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS),
    .SUM_W  (SUM_W)
  ) u_mac_tree (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_s),
    .fmap_i   (fmaps_in),
    .weight_i (w_q),
    .sum_o    (tree_sum_s)
  );

  // Valid/last tags ride alongside the datapath; S4 folds window sums into
  // the group accumulator and publishes on the group's last window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s3_vld_q  <= 1'b0;
      s3_last_q <= 1'b0;
      grp_q     <= '0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
    end else if (en_s) begin
      s1_vld_q  <= issue_s;
      s1_last_q <= issue_s && last_grp_s;
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      s3_vld_q  <= s2_vld_q;
      s3_last_q <= s2_last_q;
      if (s3_vld_q) begin
        grp_q <= s3_last_q ? '0 : acc_sum_s;
      end
      if (s3_vld_q && s3_last_q) begin
        acc_q <= acc_sum_s;
      end
      valid_q <= s3_vld_q && s3_last_q;
    end
  end

  assign weight_sel = weight_sel_q;
  assign cs         = issue_s;
  assign we         = 1'b0;
  assign fmaps_addr = addr_q;
  assign valid      = valid_q;
  assign acc        = acc_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
